// File: rtl/harq_comb_pkg.sv
// Shared types and constants for the HARQ combine scheduler and its send queue.
package harq_comb_pkg;

    localparam int NUM_USERS = 8;
    localparam int NCB_W     = 16;
    localparam int UIDX_W    = 4;
    localparam int USEL_W    = $clog2(NUM_USERS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT_COMB, ST_DRAIN, ST_DONE
    } main_state_t;

    typedef enum logic [1:0] {SIDLE, SREQ, SWAIT} send_state_t;

    typedef enum logic [1:0] {BUF_FREE, BUF_COMB, BUF_FULL} buf_state_t;

    typedef struct packed {
        logic             pingpong;
        logic [NCB_W-1:0] ncb;
    } send_entry_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [UIDX_W-1:0] lowest_user(input logic [NUM_USERS-1:0] m);
        lowest_user = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (m[i]) lowest_user = UIDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/harq_send_queue.sv
// Two-entry queue of finished combine buffers plus the SENDHARQ request engine.
module harq_send_queue
    import harq_comb_pkg::*;
(
    input  logic             i_core_clk,
    input  logic             i_rx_rst,
    input  logic             push,
    input  send_entry_t      push_entry,
    input  logic             send_comp,
    output logic             send_req,
    output logic             send_pingpong,
    output logic [NCB_W-1:0] send_ncb,
    output logic             release_vld,
    output logic             fifo_empty
);

    send_entry_t fifo_mem [2];
    logic        rd_idx;
    logic        wr_idx;
    logic [1:0]  count;
    logic        pop;
    send_state_t state, state_nxt;

    assign pop         = (state == SWAIT) && send_comp;
    assign fifo_empty  = (count == 2'd0);
    assign release_vld = pop;

    // Never pushed when full: only two buffers can be outstanding.
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_idx      <= 1'b0;
            wr_idx      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= push_entry;
                wr_idx           <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) state <= SIDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SIDLE:   if (!fifo_empty) state_nxt = SREQ;
            SREQ:    state_nxt = SWAIT;
            SWAIT:   if (send_comp) state_nxt = SIDLE;
            default: state_nxt = SIDLE;
        endcase
    end

    // Head is captured on the way into SREQ and held until the next request.
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            send_pingpong <= 1'b0;
            send_ncb      <= '0;
        end else if (state == SIDLE && !fifo_empty) begin
            send_pingpong <= fifo_mem[rd_idx].pingpong;
            send_ncb      <= fifo_mem[rd_idx].ncb;
        end
    end

    always_comb begin
        send_req = (state == SREQ);
    end

endmodule

// File: rtl/harq_combine_scheduler.sv
// Slot sequencer: walks the user mask, issues ping/pong combine jobs and hands
// finished buffers to SENDHARQ. COMB_WATCHDOG_EN adds the combine watchdog.
module harq_combine_scheduler
    import harq_comb_pkg::*;
`ifdef COMB_WATCHDOG_EN
#(
    parameter int WDOG_CYCLES = 65535
)
`endif
(
    input  logic                       i_core_clk,
    input  logic                       i_rx_rst,
    input  logic                       i_slot_start,
    input  logic [NUM_USERS-1:0]       i_user_mask,
    input  logic [NUM_USERS*NCB_W-1:0] i_users_ncb,
    output logic                       o_combine_req,
    output logic [UIDX_W-1:0]          o_combine_user_index,
    output logic                       o_combine_buf,
    input  logic                       i_combine_comp,
    output logic                       o_sendharq_req,
    output logic                       o_sendharq_pingpong,
    output logic [NCB_W-1:0]           o_sendharq_ncb,
    input  logic                       i_sendharq_comp,
    output logic                       o_slot_done,
    output logic                       o_busy,
    output logic                       o_overrun,
    output logic [3:0]                 o_skip_cnt
`ifdef COMB_WATCHDOG_EN
    ,
    output logic                       o_wdog_err,
    output logic                       o_comb_fsm_rst
`endif
);

    main_state_t          state, state_nxt;
    logic [NUM_USERS-1:0] pend;
    logic [UIDX_W-1:0]    scan_k, cur_k;
    logic [NCB_W-1:0]     scan_ncb, cur_ncb;
    logic                 scan_skip;
    logic                 wr_ptr;
    buf_state_t           buf_state [2];
    logic                 issue, comb_done, wdog_fire;
    logic                 release_vld, fifo_empty, drain_ok;

    assign scan_k    = lowest_user(pend);
    assign scan_ncb  = i_users_ncb[int'(scan_k)*NCB_W +: NCB_W];
    assign scan_skip = (scan_ncb[NCB_W-1:4] == '0);
    assign issue     = (state == ST_ISSUE) && (buf_state[wr_ptr] == BUF_FREE);
    assign comb_done = (state == ST_WAIT_COMB) && i_combine_comp;
    assign drain_ok  = (buf_state[0] == BUF_FREE) && (buf_state[1] == BUF_FREE) && fifo_empty;

`ifdef COMB_WATCHDOG_EN
    logic [15:0] wdog_cnt;

    // A completion in the same cycle as expiry wins over the watchdog.
    assign wdog_fire      = (state == ST_WAIT_COMB) && !i_combine_comp
                            && (wdog_cnt == 16'(WDOG_CYCLES - 1));
    assign o_comb_fsm_rst = wdog_fire;

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            wdog_cnt   <= '0;
            o_wdog_err <= 1'b0;
        end else begin
            wdog_cnt <= (state == ST_WAIT_COMB) ? wdog_cnt + 16'd1 : 16'd0;
            if (wdog_fire) o_wdog_err <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (i_slot_start) state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (pend == '0)     state_nxt = ST_DRAIN;
                else if (!scan_skip) state_nxt = ST_ISSUE;
            end
            ST_ISSUE:     if (issue) state_nxt = ST_WAIT_COMB;
            ST_WAIT_COMB: if (comb_done || wdog_fire) state_nxt = ST_SCAN;
            ST_DRAIN:     if (drain_ok) state_nxt = ST_DONE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_combine_req        = issue;
        o_combine_user_index = cur_k;
        o_combine_buf        = wr_ptr;
        o_slot_done          = (state == ST_DONE);
        o_busy               = (state != ST_IDLE);
    end

    // wr_ptr tracks the combine datapath's own ping/pong toggle.
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            pend       <= '0;
            cur_k      <= '0;
            cur_ncb    <= '0;
            wr_ptr     <= 1'b0;
            o_skip_cnt <= '0;
            o_overrun  <= 1'b0;
        end else begin
            if (i_slot_start && state != ST_IDLE) o_overrun <= 1'b1;
            case (state)
                ST_IDLE: if (i_slot_start) begin
                    pend       <= i_user_mask;
                    o_skip_cnt <= '0;
                end
                ST_SCAN: if (pend != '0) begin
                    if (scan_skip) begin
                        pend[scan_k[USEL_W-1:0]] <= 1'b0;
                        if (o_skip_cnt != 4'hF) o_skip_cnt <= o_skip_cnt + 4'd1;
                    end else begin
                        cur_k   <= scan_k;
                        cur_ncb <= scan_ncb;
                    end
                end
                ST_WAIT_COMB: begin
                    if (comb_done) begin
                        pend[cur_k[USEL_W-1:0]] <= 1'b0;
                        wr_ptr                  <= ~wr_ptr;
                    end else if (wdog_fire) begin
                        pend[cur_k[USEL_W-1:0]] <= 1'b0;
                        wr_ptr                  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Release targets a FULL buffer, issue a FREE one, completion a COMB one,
    // so the branches never collide on the same buffer.
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            buf_state[0] <= BUF_FREE;
            buf_state[1] <= BUF_FREE;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (release_vld && o_sendharq_pingpong == 1'(i))
                    buf_state[i] <= BUF_FREE;
                else if (issue && wr_ptr == 1'(i))
                    buf_state[i] <= BUF_COMB;
                else if (comb_done && wr_ptr == 1'(i))
                    buf_state[i] <= BUF_FULL;
                else if (wdog_fire && wr_ptr == 1'(i))
                    buf_state[i] <= BUF_FREE;
            end
        end
    end

    harq_send_queue u_send_queue (
        .i_core_clk    (i_core_clk),
        .i_rx_rst      (i_rx_rst),
        .push          (comb_done),
        .push_entry    (send_entry_t'{pingpong: wr_ptr, ncb: cur_ncb}),
        .send_comp     (i_sendharq_comp),
        .send_req      (o_sendharq_req),
        .send_pingpong (o_sendharq_pingpong),
        .send_ncb      (o_sendharq_ncb),
        .release_vld   (release_vld),
        .fifo_empty    (fifo_empty)
    );

endmodule
